xmt_serial: RTL and testbench

- Serial byte transmitter, the send-side counterpart of the rcv_top receive path.
- Accepts an 8-bit byte over a valid/ready handshake and serialises it as one frame: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- Bit timing comes from an internal clock divider.
- Sits at the chip boundary, driving the line that a receiver block samples.

---
 rtl/xmt_serial_if.sv | 28 ++
 rtl/xmt_serial.sv | 151 +++++++++++++++
 tb/tb_xmt_serial.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/xmt_serial_if.sv
// rtl/xmt_serial_if.sv - byte handshake and serial line bundle for xmt_serial
// The design side uses the slave modport; the upstream byte source uses master.
interface xmt_serial_if;
  logic [7:0] xmt_data;
  logic       xmt_valid;
  logic       xmt_ready;
  logic       xmt_serial;
  logic       xmt_busy;
  logic       xmt_done;

  modport master (
    output xmt_data,
    output xmt_valid,
    input  xmt_ready,
    input  xmt_serial,
    input  xmt_busy,
    input  xmt_done
  );

  modport slave (
    input  xmt_data,
    input  xmt_valid,
    output xmt_ready,
    output xmt_serial,
    output xmt_busy,
    output xmt_done
  );
endinterface

// File: rtl/xmt_serial.sv
// rtl/xmt_serial.sv - serial byte transmitter: start, 8 data LSB first, optional parity, stop
// Every output is driven straight from a register so the line is glitch-free at the pad.
module xmt_serial #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic          xmt_clk,
  input  logic          xmt_rst_n,
  xmt_serial_if.slave   bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          serial_q, serial_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic bit_end;
  logic handshake;

  assign bit_end   = (cyc_q == CYC_LAST);
  assign handshake = bus.xmt_valid & ready_q & (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    serial_d = serial_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    // Bit-period divider runs whenever a frame is on the line
    if (state_q != IDLE) begin
      cyc_d = bit_end ? '0 : cyc_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        cyc_d = '0;
        bit_d = 3'd0;
        if (handshake) begin
          shift_d  = bus.xmt_data;
          par_d    = (^bus.xmt_data) ^ PARITY_ODD;
          state_d  = START;
          serial_d = 1'b0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          state_d  = DATA;
          serial_d = shift_q[0];
          shift_d  = {1'b0, shift_q[7:1]};
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            if (PARITY_EN) begin
              state_d  = PARITY;
              serial_d = par_q;
            end else begin
              state_d  = STOP;
              serial_d = 1'b1;
            end
          end else begin
            bit_d    = bit_q + 3'd1;
            serial_d = shift_q[0];
            shift_d  = {1'b0, shift_q[7:1]};
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          state_d  = STOP;
          serial_d = 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          state_d  = IDLE;
          serial_d = 1'b1;
          ready_d  = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        cyc_d    = '0;
        bit_d    = 3'd0;
        serial_d = 1'b1;
        ready_d  = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge xmt_clk or negedge xmt_rst_n) begin
    if (!xmt_rst_n) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      par_q    <= 1'b0;
      serial_q <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.xmt_serial = serial_q;
  assign bus.xmt_ready  = ready_q;
  assign bus.xmt_busy   = busy_q;
  assign bus.xmt_done   = done_q;

endmodule

// File: tb/tb_xmt_serial.sv
// tb/tb_xmt_serial.sv - directed bench for xmt_serial across four parameter sets
// Frames are written as {stop, parity, data[7:0], start} so bit i is the i-th line bit.
module tb_xmt_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tb_data;
  logic       tb_valid;
  int         sel;
  int         n_chk;
  int         n_err;

  logic mon_serial, mon_ready, mon_busy, mon_done;

  always #5 clk = ~clk;

  xmt_serial_if ifa ();
  xmt_serial_if ifb ();
  xmt_serial_if ifc ();
  xmt_serial_if ifd ();

  assign ifa.xmt_data  = tb_data;
  assign ifb.xmt_data  = tb_data;
  assign ifc.xmt_data  = tb_data;
  assign ifd.xmt_data  = tb_data;
  assign ifa.xmt_valid = tb_valid && (sel == 0);
  assign ifb.xmt_valid = tb_valid && (sel == 1);
  assign ifc.xmt_valid = tb_valid && (sel == 2);
  assign ifd.xmt_valid = tb_valid && (sel == 3);

  // a: 4 clk/bit even, b: 4 clk/bit odd, c: 4 clk/bit no parity, d: 1 clk/bit even
  xmt_serial #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0))
    u_a (.xmt_clk(clk), .xmt_rst_n(rst_n), .bus(ifa));
  xmt_serial #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1))
    u_b (.xmt_clk(clk), .xmt_rst_n(rst_n), .bus(ifb));
  xmt_serial #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0))
    u_c (.xmt_clk(clk), .xmt_rst_n(rst_n), .bus(ifc));
  xmt_serial #(.CLKS_PER_BIT(1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0))
    u_d (.xmt_clk(clk), .xmt_rst_n(rst_n), .bus(ifd));

  always_comb begin
    mon_serial = ifa.xmt_serial;
    mon_ready  = ifa.xmt_ready;
    mon_busy   = ifa.xmt_busy;
    mon_done   = ifa.xmt_done;
    case (sel)
      1: begin
        mon_serial = ifb.xmt_serial; mon_ready = ifb.xmt_ready;
        mon_busy   = ifb.xmt_busy;   mon_done  = ifb.xmt_done;
      end
      2: begin
        mon_serial = ifc.xmt_serial; mon_ready = ifc.xmt_ready;
        mon_busy   = ifc.xmt_busy;   mon_done  = ifc.xmt_done;
      end
      3: begin
        mon_serial = ifd.xmt_serial; mon_ready = ifd.xmt_ready;
        mon_busy   = ifd.xmt_busy;   mon_done  = ifd.xmt_done;
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input logic [7:0] d);
    check({tag, "_ready"}, 32'(mon_ready), 32'd1);
    tb_data  = d;
    tb_valid = 1'b1;
    tick();
    tb_valid = 1'b0;
  endtask

  // Called in cycle 1 after the handshake; returns in the cycle where done should pulse.
  task automatic run_frame(input string tag, input logic [10:0] frame, input int nbits,
                           input int cpb, input int poke);
    int busy_cnt;
    busy_cnt = 0;
    for (int k = 1; k <= nbits * cpb; k++) begin
      if (poke > 0 && k == poke) begin
        tb_data  = 8'h3C;
        tb_valid = 1'b1;
        check({tag, "_poke_ready"}, 32'(mon_ready), 32'd0);
      end
      if (poke > 0 && k == poke + 1) tb_valid = 1'b0;
      check($sformatf("%s_c%0d", tag, k), 32'(mon_serial), 32'(frame[(k - 1) / cpb]));
      if (mon_busy) busy_cnt++;
      if (mon_done) check($sformatf("%s_early_done_c%0d", tag, k), 32'(mon_done), 32'd0);
      tick();
    end
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(nbits * cpb));
    check({tag, "_done"},        32'(mon_done),   32'd1);
    check({tag, "_done_ready"},  32'(mon_ready),  32'd1);
    check({tag, "_done_busy"},   32'(mon_busy),   32'd0);
    check({tag, "_done_line"},   32'(mon_serial), 32'd1);
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    sel      = 0;
    tb_data  = 8'h00;
    tb_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (3) tick();
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #0;
      check($sformatf("rst%0d_line", s),  32'(mon_serial), 32'd1);
      check($sformatf("rst%0d_ready", s), 32'(mon_ready),  32'd1);
      check($sformatf("rst%0d_busy", s),  32'(mon_busy),   32'd0);
      check($sformatf("rst%0d_done", s),  32'(mon_done),   32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // even parity, 0xA5: parity 0
    sel = 0;
    send("a5", 8'hA5);
    run_frame("a5", 11'b1_0_10100101_0, 11, 4, 0);
    tick();
    check("a5_done_clear", 32'(mon_done), 32'd0);

    // odd parity 0x01 -> 0; even 0x01 -> 1; no parity 0x01 -> 40-cycle frame
    sel = 1;
    send("odd01", 8'h01);
    run_frame("odd01", 11'b1_0_00000001_0, 11, 4, 0);
    tick();
    sel = 0;
    send("even01", 8'h01);
    run_frame("even01", 11'b1_1_00000001_0, 11, 4, 0);
    tick();
    sel = 2;
    send("nopar01", 8'h01);
    run_frame("nopar01", 11'b0_1_00000001_0, 10, 4, 0);
    tick();

    // back-to-back 0x00 then 0xFF with valid held high
    sel = 0;
    check("b2b_ready", 32'(mon_ready), 32'd1);
    tb_data  = 8'h00;
    tb_valid = 1'b1;
    tick();
    tb_data = 8'hFF;
    run_frame("b2b0", 11'b1_0_00000000_0, 11, 4, 0);
    tick();
    tb_valid = 1'b0;
    check("b2b_second_start", 32'(mon_serial), 32'd0);
    check("b2b_second_busy",  32'(mon_busy),   32'd1);
    run_frame("b2b1", 11'b1_0_11111111_0, 11, 4, 0);
    tick();

    // valid pulsed with 0x3C while busy must not disturb 0x5A
    send("busy5a", 8'h5A);
    run_frame("busy5a", 11'b1_0_01011010_0, 11, 4, 10);
    tick();
    check("busy5a_no_hs_line", 32'(mon_serial), 32'd1);
    check("busy5a_no_hs_busy", 32'(mon_busy),   32'd0);

    // asynchronous reset during data bit 3 of 0x96 (bit 3 = 0)
    send("rst96", 8'h96);
    repeat (16) tick();
    check("rst96_in_bit3", 32'(mon_serial), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst96_async_line",  32'(mon_serial), 32'd1);
    check("rst96_async_busy",  32'(mon_busy),   32'd0);
    check("rst96_async_ready", 32'(mon_ready),  32'd1);
    check("rst96_async_done",  32'(mon_done),   32'd0);
    repeat (2) begin
      tick();
      check("rst96_hold_done", 32'(mon_done),   32'd0);
      check("rst96_hold_line", 32'(mon_serial), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst96_after_done", 32'(mon_done), 32'd0);
    send("post_rst", 8'hA5);
    run_frame("post_rst", 11'b1_0_10100101_0, 11, 4, 0);
    tick();

    // one clock per bit, 0x80: parity 1, done in cycle 12
    sel = 3;
    send("cpb1", 8'h80);
    run_frame("cpb1", 11'b1_1_10000000_0, 11, 1, 0);
    tick();
    check("cpb1_done_clear", 32'(mon_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
